// File: rtl/aes_bus_pkg.sv
// aes_bus_pkg: shared types and constants for the AES128 bus controller.
//   AES_BLK_W : AES block / key width (128)
//   state_t   : controller FSM states
//   aes_blk_t : 128-bit block, bit 0 is the most significant (first bus word)
package aes_bus_pkg;
   localparam int AES_BLK_W = 128;
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, STORE} state_t;
   typedef logic [0:AES_BLK_W-1] aes_blk_t;
endpackage

// File: rtl/aes_bus_ctrl_if.sv
// aes_bus_ctrl_if: host bus + AES128 core signals of aes_bus_ctrl.
//   host  -> ctrl : wr_en, sel_key, ch, wdata, rd_en, go, decrypt
//   ctrl  -> host : rdata, rvalid, busy, done, err
//   ctrl  -> core : core_start, core_sel, core_msg, core_key
//   core  -> ctrl : core_result, core_done
//   modport slave is the controller side, master is the host/core side.
interface aes_bus_ctrl_if #(
   parameter int BUS_W  = 32,
   parameter int NUM_CH = 2
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   logic wr_en, sel_key, rd_en, go, decrypt;
   logic rvalid, busy, done, err;
   logic core_start, core_sel, core_done;
   logic [CH_W-1:0] ch;
   logic [BUS_W-1:0] wdata, rdata;
   aes_bus_pkg::aes_blk_t core_msg, core_key, core_result;
   modport master (
      output wr_en, sel_key, ch, wdata, rd_en, go, decrypt, core_result, core_done,
      input  rdata, rvalid, busy, done, err, core_start, core_sel, core_msg, core_key
   );
   modport slave (
      input  wr_en, sel_key, ch, wdata, rd_en, go, decrypt, core_result, core_done,
      output rdata, rvalid, busy, done, err, core_start, core_sel, core_msg, core_key
   );
endinterface

// File: rtl/aes_blk_shreg.sv
// aes_blk_shreg: one 128-bit block assembled from BUS_W-bit words.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_wr_en        : write one word at the current pointer
//   i_wdata        : write word (first word lands in the most significant bits)
//   o_blk          : assembled block
//   o_full         : set after the last word; a write at pointer 0 while full
//                    restarts the block and clears it
module aes_blk_shreg
   import aes_bus_pkg::*;
#(
   parameter int BUS_W = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_wr_en,
   input  logic [BUS_W-1:0] i_wdata,
   output aes_blk_t         o_blk,
   output logic             o_full
);
   localparam int WORDS = AES_BLK_W / BUS_W;
   localparam int PTR_W = $clog2(WORDS);
   aes_blk_t         r_blk;
   logic [PTR_W-1:0] r_ptr;
   logic             r_full;
   // WORDS is a power of two, so the pointer wraps naturally; full can only be
   // set while the pointer sits at 0, so any write recomputes it correctly
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_blk  <= '0;
         r_ptr  <= '0;
         r_full <= 1'b0;
      end else if (i_wr_en) begin
         r_blk[int'(r_ptr) * BUS_W +: BUS_W] <= i_wdata;
         r_ptr  <= r_ptr + 1'b1;
         r_full <= r_ptr == PTR_W'(WORDS - 1);
      end
   end
   assign o_blk  = r_blk;
   assign o_full = r_full;
endmodule

// File: rtl/aes_bus_ctrl.sv
// aes_bus_ctrl: multi-channel bus front end for the AES128 core.
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus (slave)    : host write/read/launch strobes, status (busy/done/err),
//                    core handshake (core_start/sel/msg/key, core_result/done)
//   Optional AES_TIMEOUT_EN: abort a launch after TIMEOUT_CYC cycles in WAIT.
module aes_bus_ctrl
   import aes_bus_pkg::*;
#(
   parameter int BUS_W       = 32,
   parameter int NUM_CH      = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic          i_clk,
   input  logic          i_reset,
   aes_bus_ctrl_if.slave bus
);
   localparam int WORDS = AES_BLK_W / BUS_W;
   localparam int PTR_W = $clog2(WORDS);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   if (!(BUS_W == 8 || BUS_W == 16 || BUS_W == 32 || BUS_W == 64) || NUM_CH < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("aes_bus_ctrl: illegal BUS_W/NUM_CH/TIMEOUT_CYC");
   end
   state_t            r_state;
   logic [CH_W-1:0]   r_ch;
   logic              r_core_start, r_core_sel, r_busy, r_done, r_err, r_rvalid;
   logic [BUS_W-1:0]  r_rdata;
   aes_blk_t          r_core_msg, r_core_key;
   aes_blk_t          r_res [NUM_CH];
   logic [PTR_W-1:0]  r_rptr [NUM_CH];
   logic [NUM_CH-1:0] r_res_vld;
   aes_blk_t          w_msg [NUM_CH];
   aes_blk_t          w_key [NUM_CH];
   logic [NUM_CH-1:0] w_msg_full, w_key_full;
   logic              w_go_ok, w_wr_drop, w_rd_ok, w_store, w_tmo;
   // go sees the registered flags, i.e. the state before a same-cycle write
   assign w_go_ok   = r_state == IDLE && w_msg_full[bus.ch] && w_key_full[bus.ch];
   assign w_wr_drop = bus.wr_en && r_state != IDLE && bus.ch == r_ch;
   assign w_rd_ok   = bus.rd_en && r_res_vld[bus.ch];
   assign w_store   = r_state == WAIT && bus.core_done;
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      aes_blk_shreg #(.BUS_W(BUS_W)) u_msg (
         .i_clk   (i_clk),
         .i_reset (i_reset),
         .i_wr_en (bus.wr_en && !w_wr_drop && !bus.sel_key && bus.ch == CH_W'(c)),
         .i_wdata (bus.wdata),
         .o_blk   (w_msg[c]),
         .o_full  (w_msg_full[c])
      );
      aes_blk_shreg #(.BUS_W(BUS_W)) u_key (
         .i_clk   (i_clk),
         .i_reset (i_reset),
         .i_wr_en (bus.wr_en && !w_wr_drop && bus.sel_key && bus.ch == CH_W'(c)),
         .i_wdata (bus.wdata),
         .o_blk   (w_key[c]),
         .o_full  (w_key_full[c])
      );
   end
`ifdef AES_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] r_cnt;
   // r_cnt holds the number of WAIT cycles already elapsed
   assign w_tmo = r_state == WAIT && !bus.core_done && r_cnt == CNT_W'(TIMEOUT_CYC - 1);
   always_ff @(posedge i_clk)
      r_cnt <= (i_reset || r_state != WAIT) ? '0 : r_cnt + 1'b1;
`else
   assign w_tmo = 1'b0;
`endif
   // msg/key are copied at launch so the core sees a stable block even if the
   // channel is rewritten in the launch cycle
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= IDLE;
         r_ch         <= '0;
         r_core_start <= 1'b0;
         r_core_sel   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_core_msg   <= '0;
         r_core_key   <= '0;
      end else begin
         r_core_start <= 1'b0;
         r_done       <= 1'b0;
         case (r_state)
            IDLE: if (bus.go && w_go_ok) begin
               r_state      <= LAUNCH;
               r_ch         <= bus.ch;
               r_core_sel   <= bus.decrypt;
               r_core_msg   <= w_msg[bus.ch];
               r_core_key   <= w_key[bus.ch];
               r_core_start <= 1'b1;
               r_busy       <= 1'b1;
            end
            LAUNCH: r_state <= WAIT;
            WAIT: if (w_store) begin
               r_state <= STORE;
               r_done  <= 1'b1;
            end else if (w_tmo) begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            STORE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge i_clk)
      r_err <= !i_reset && ((bus.go && !w_go_ok) || w_wr_drop || (bus.rd_en && !w_rd_ok) || w_tmo);
   // core_result is only valid with core_done, so it is captured on that cycle;
   // the STORE cycle then announces it with done
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_res_vld <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_res[i]  <= '0;
            r_rptr[i] <= '0;
         end
      end else begin
         r_rvalid <= w_rd_ok;
         r_rdata  <= w_rd_ok ? r_res[bus.ch][int'(r_rptr[bus.ch]) * BUS_W +: BUS_W] : '0;
         if (w_rd_ok)
            r_rptr[bus.ch] <= r_rptr[bus.ch] + 1'b1;
         if (w_store) begin
            r_res[r_ch]     <= bus.core_result;
            r_res_vld[r_ch] <= 1'b1;
            r_rptr[r_ch]    <= '0;
         end
      end
   end
   assign bus.rdata      = r_rdata;
   assign bus.rvalid     = r_rvalid;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.err        = r_err;
   assign bus.core_start = r_core_start;
   assign bus.core_sel   = r_core_sel;
   assign bus.core_msg   = r_core_msg;
   assign bus.core_key   = r_core_key;
endmodule
